tx_order_arbiter: RTL and testbench
===================================

# tx_order_arbiter

Parametrised arrival-order arbiter for the TL transmit path, replacing the fixed four-source arbiter and its separate sequence recorder with one self-contained block. It watches the request lines of `NUM_SRC` transmit sources (A2P read, A2P write, master completion, Rx router, and so on) and records each new request's source index in an internal order FIFO. When several requests arrive in the same cycle, they are recorded in ascending index order. The FIFO head is presented downstream as a valid/ready grant, and a source re-arms automatically after each grant.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of requesting sources. Must be ≥2.
- `FIFO_DEPTH`, default 8: order FIFO entries. Must be ≥`NUM_SRC`. Need not be a power of two.
- `ID_W`, default `$clog2(NUM_SRC)`: width of a source index.
- `CNT_W`, default `$clog2(FIFO_DEPTH+1)`: width of the occupancy count.

Ports:
- `clk`  in  1  clock. All logic is on the rising edge.
- `arst`  in  1  reset. Synchronous, active-low (one clock; reset is synchronous and active-low).
- `req_valid`  in  `NUM_SRC`  level request per source. Held high while the source has a TLP to send.
- `src_en`  in  `NUM_SRC`  per-source record enable.
- `clear`  in  1  synchronous flush of the FIFO and all pending state.
- `grant_valid`  out  1  FIFO non-empty.
- `grant_id`  out  `ID_W`  source index at the FIFO head.
- `grant_ready`  in  1  downstream accepts the head entry.
- `pending`  out  `NUM_SRC`  source has an entry in the FIFO.
- `occupancy`  out  `CNT_W`  number of FIFO entries.

## Operation
- State: storage `mem[FIFO_DEPTH]` of `ID_W` bits, `wr_ptr`/`rd_ptr` (0..`FIFO_DEPTH`-1), `count`, and a `pending` bitmap.
- Eligibility: `elig = req_valid & src_en & ~pending`.
  - Each eligible source is pushed exactly once per request.
  - The FIFO cannot overflow, because at most `NUM_SRC` entries are ever outstanding.
- Push order:
  - Eligible sources are written to slots `wr_ptr+0`, `wr_ptr+1`, … (mod `FIFO_DEPTH`), in ascending source index.
  - `wr_ptr` advances by `popcount(elig)`, mod `FIFO_DEPTH`.
  - `pending` bits for the pushed sources are set.
- Pop: a pop happens when `grant_valid & grant_ready`.
  - `rd_ptr` advances by 1, mod `FIFO_DEPTH`.
  - `pending[grant_id]` is cleared.
- Pop is single-entry per cycle. `grant_ready` while the FIFO is empty is ignored.
- Simultaneous push and pop: both take effect; `count` becomes `count + popcount(elig) - pop`.
- Re-arm after a grant:
  - A source whose `req_valid` stays high after its grant is re-eligible the cycle after the pop, so it is queued behind any other waiting sources (round-robin fairness).
  - The popped source is not eligible in its own pop cycle, because `pending` is still set.
- Dropped request: deasserting `req_valid` while pending does not remove the entry. Downstream must tolerate the stale grant.
- `src_en` low blocks new records only. Entries already queued remain.
- `clear` has priority over push and pop:
  - The next state is empty: pointers 0, `count` 0, `pending` 0.
  - Requests present during `clear` are not recorded. They are recorded on the first cycle after `clear` drops.
- Reset (`arst`=0 at a rising edge) has the same effect as `clear`. It overrides all inputs and may occur mid-operation.

## Timing
- Reset values: `grant_valid`=0, `grant_id`=0, `pending`=0, `occupancy`=0.
- Output derivation:
  - `grant_id` = `mem[rd_ptr]` and `grant_valid` = (`count`≠0), both combinational from registers.
  - `pending` and `occupancy` are direct register outputs.
- Latency: a request that is eligible in cycle t gives `grant_valid`/`grant_id` in cycle t+1, if the FIFO was empty. No combinational path runs from `req_valid` to the grant outputs.
- Same-source grant spacing is at least 2 cycles (pop in cycle t, re-record in t+1, grant no earlier than t+2).
- Throughput: one grant per cycle while the FIFO is non-empty and `grant_ready`=1.
- `grant_id` is stable while `grant_valid`=1 and `grant_ready`=0.

## Test plan
- Single request: reset, then `req_valid`=4'b0100 at cycle 1.
  - Cycle 2: `grant_valid`=1, `grant_id`=2, `pending`=4'b0100, `occupancy`=1.
  - Pulse `grant_ready` at cycle 2. Cycle 3: `occupancy`=0, and `grant_valid`=0 because source 2 re-records.
  - Cycle 4: `grant_id`=2 again.
- Simultaneous arrival: `req_valid`=4'b1111 for one cycle, with `grant_ready`=1 thereafter.
  - Grants appear on 4 consecutive cycles with `grant_id` 0,1,2,3.
  - `occupancy` goes 4,3,2,1,0, ignoring re-arm since `req_valid` dropped.
- Fairness: source 0 held high, source 3 raised one cycle later, `grant_ready`=1.
  - `grant_id` sequence is 0,3,0,3,….
  - Source 0 is never granted twice consecutively while source 3 is pending.
- Wrap and concurrent push/pop: `NUM_SRC`=4, `FIFO_DEPTH`=5.
  - Use random `req_valid` and `grant_ready` for 1000 cycles.
  - The scoreboard order matches a reference queue.
  - `occupancy` never exceeds 4, and pointers wrap from 4 to 0 correctly.
- `clear` mid-operation: with 3 entries queued, assert `clear` for 1 cycle while `req_valid`=4'b0011.
  - Next cycle: `occupancy`=0, `pending`=0.
  - The cycle after: `occupancy`=2, `grant_id`=0.
- Reset mid-operation: drive `arst`=0 for 1 cycle with a full queue and `grant_ready`=1.
  - All outputs return to their reset values on the next cycle.
  - No pop is counted in the reset cycle.

Source files
------------

// File: rtl/tx_order_arbiter_if.sv
// Request/grant bundle for tx_order_arbiter. The arbiter sits on the slave modport.
// The transmit-path sources and the downstream consumer share the master modport.
interface tx_order_arbiter_if #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ID_W       = $clog2(NUM_SRC),
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
);
  logic [NUM_SRC-1:0] req_valid;
  logic [NUM_SRC-1:0] src_en;
  logic               clear;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic               grant_ready;
  logic [NUM_SRC-1:0] pending;
  logic [CNT_W-1:0]   occupancy;

  modport slave (
    input  req_valid, src_en, clear, grant_ready,
    output grant_valid, grant_id, pending, occupancy
  );

  modport master (
    output req_valid, src_en, clear, grant_ready,
    input  grant_valid, grant_id, pending, occupancy
  );
endinterface

// File: rtl/tx_order_arbiter.sv
// Arrival-order arbiter: new requests are logged in an order FIFO, in ascending index
// when several arrive together. The FIFO head is offered downstream as a valid/ready grant.
module tx_order_arbiter #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ID_W       = $clog2(NUM_SRC),
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                arst,
  tx_order_arbiter_if.slave   bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int SUM_W = PTR_W + 1;

  logic [ID_W-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] popMask;
  logic [PTR_W-1:0]   slot [NUM_SRC];
  logic [CNT_W-1:0]   pushCnt;
  logic               pop;

  // Modular pointer advance. The sum stays below 2*FIFO_DEPTH, so one subtraction is enough.
  function automatic logic [PTR_W-1:0] ptrAdd(input logic [PTR_W-1:0] base,
                                              input logic [CNT_W-1:0] inc);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(base) + SUM_W'(inc);
    if (sum >= SUM_W'(FIFO_DEPTH)) begin
      sum = sum - SUM_W'(FIFO_DEPTH);
    end
    return sum[PTR_W-1:0];
  endfunction

  always_comb begin
    elig    = bus.req_valid & bus.src_en & ~pending_q;
    pushCnt = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      slot[i] = ptrAdd(wrPtr_q, pushCnt);
      if (elig[i]) begin
        pushCnt = pushCnt + CNT_W'(1);
      end
    end

    pop     = (count_q != '0) && bus.grant_ready;
    popMask = '0;
    if (pop) begin
      popMask = NUM_SRC'(1) << mem_q[rdPtr_q];
    end

    wrPtr_d   = ptrAdd(wrPtr_q, pushCnt);
    rdPtr_d   = pop ? ptrAdd(rdPtr_q, CNT_W'(1)) : rdPtr_q;
    count_d   = count_q + pushCnt - CNT_W'(pop);
    // The popped source is still pending in its pop cycle, so it re-arms one cycle later.
    pending_d = (pending_q | elig) & ~popMask;
  end

  always_ff @(posedge clk) begin
    if (!arst || bus.clear) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      pending_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (elig[i]) begin
          mem_q[slot[i]] <= ID_W'(i);
        end
      end
    end
  end

  assign bus.grant_valid = (count_q != '0);
  assign bus.grant_id    = mem_q[rdPtr_q];
  assign bus.pending     = pending_q;
  assign bus.occupancy   = count_q;
endmodule

// File: tb/tb_tx_order_arbiter.sv
// Bench for tx_order_arbiter: a queue-based order model fed by the driver and drained by a
// monitor, plus directed scenarios and a randomized run on a 5-deep FIFO to exercise wrap.
module tb_tx_order_arbiter;
  localparam int NSRC  = 4;
  localparam int DEPTH = 5;

  logic clk;
  logic arst;
  int   nCompared;
  int   nMismatched;
  int   expQ[$];

  tx_order_arbiter_if #(.NUM_SRC(NSRC), .FIFO_DEPTH(DEPTH)) bus ();

  tx_order_arbiter #(.NUM_SRC(NSRC), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual != expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic bit inQ(input int id);
    foreach (expQ[k]) if (expQ[k] == id) return 1'b1;
    return 1'b0;
  endfunction

  // Inputs change on the falling edge; the model records arrivals after the monitor has run.
  task automatic applyStimulus(input logic [NSRC-1:0] req, input logic [NSRC-1:0] en,
                               input bit clr, input bit rst, input bit rdy);
    int stage[$];
    @(negedge clk);
    bus.req_valid   = req;
    bus.src_en      = en;
    bus.clear       = clr;
    bus.grant_ready = rdy;
    arst            = ~rst;
    stage = {};
    for (int i = 0; i < NSRC; i++) begin
      if (req[i] && en[i] && !inQ(i)) stage.push_back(i);
    end
    #3;
    if (clr || rst) expQ.delete();
    else foreach (stage[k]) expQ.push_back(stage[k]);
  endtask

  // Monitor: compares the visible state with the model, and retires the head on a handshake.
  always begin
    int bm;
    @(negedge clk);
    #2;
    bm = 0;
    foreach (expQ[k]) bm |= (1 << expQ[k]);
    checkOutput("occupancy", int'(bus.occupancy), expQ.size());
    checkOutput("grant_valid", int'(bus.grant_valid), int'(expQ.size() != 0));
    checkOutput("pending", int'(bus.pending), bm);
    checkOutput("occupancy_bound", int'(bus.occupancy <= NSRC), 1);
    if (expQ.size() != 0) begin
      checkOutput("grant_id", int'(bus.grant_id), expQ[0]);
      if (bus.grant_ready) void'(expQ.pop_front());
    end
  end

  initial begin
    logic [NSRC-1:0] req, en;
    nCompared       = 0;
    nMismatched     = 0;
    arst            = 1'b0;
    bus.req_valid   = '0;
    bus.src_en      = '1;
    bus.clear       = 1'b0;
    bus.grant_ready = 1'b0;

    applyStimulus(4'b0000, 4'hF, 0, 1, 0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0);
    checkOutput("reset_grant_valid", int'(bus.grant_valid), 0);
    checkOutput("reset_grant_id", int'(bus.grant_id), 0);
    checkOutput("reset_pending", int'(bus.pending), 0);
    checkOutput("reset_occupancy", int'(bus.occupancy), 0);

    // Single request and its automatic re-arm.
    applyStimulus(4'b0100, 4'hF, 0, 0, 0);
    applyStimulus(4'b0100, 4'hF, 0, 0, 1);
    checkOutput("single_valid", int'(bus.grant_valid), 1);
    checkOutput("single_id", int'(bus.grant_id), 2);
    checkOutput("single_pending", int'(bus.pending), 4);
    checkOutput("single_occ", int'(bus.occupancy), 1);
    applyStimulus(4'b0100, 4'hF, 0, 0, 0);
    checkOutput("rearm_occ", int'(bus.occupancy), 0);
    checkOutput("rearm_valid", int'(bus.grant_valid), 0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0);
    checkOutput("rearm_id", int'(bus.grant_id), 2);
    checkOutput("rearm_valid2", int'(bus.grant_valid), 1);
    applyStimulus(4'b0000, 4'hF, 0, 0, 1);

    // Simultaneous arrival drains in ascending index.
    applyStimulus(4'b1111, 4'hF, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0000, 4'hF, 0, 0, 1);
      checkOutput("simul_id", int'(bus.grant_id), k);
      checkOutput("simul_occ", int'(bus.occupancy), 4 - k);
    end
    applyStimulus(4'b0000, 4'hF, 0, 0, 0);
    checkOutput("simul_empty", int'(bus.occupancy), 0);

    // Fairness: a held source alternates with a later one.
    applyStimulus(4'b0001, 4'hF, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'b1001, 4'hF, 0, 0, 1);
      checkOutput("fair_id", int'(bus.grant_id), (k % 2 == 0) ? 0 : 3);
    end
    applyStimulus(4'b0000, 4'hF, 1, 0, 0);

    // Clear with three entries queued and requests present.
    applyStimulus(4'b0111, 4'hF, 0, 0, 0);
    applyStimulus(4'b0011, 4'hF, 1, 0, 0);
    checkOutput("preclear_occ", int'(bus.occupancy), 3);
    applyStimulus(4'b0011, 4'hF, 0, 0, 0);
    checkOutput("clear_occ", int'(bus.occupancy), 0);
    checkOutput("clear_pending", int'(bus.pending), 0);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0);
    checkOutput("postclear_occ", int'(bus.occupancy), 2);
    checkOutput("postclear_id", int'(bus.grant_id), 0);

    // Reset with a full queue and a ready downstream.
    applyStimulus(4'b1111, 4'hF, 0, 0, 0);
    applyStimulus(4'b1111, 4'hF, 0, 1, 1);
    checkOutput("prereset_occ", int'(bus.occupancy), 4);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0);
    checkOutput("midreset_valid", int'(bus.grant_valid), 0);
    checkOutput("midreset_id", int'(bus.grant_id), 0);
    checkOutput("midreset_pending", int'(bus.pending), 0);
    checkOutput("midreset_occ", int'(bus.occupancy), 0);

    // Randomized traffic: concurrent push/pop, pointer wrap, occasional enable gaps and clears.
    for (int c = 0; c < 1000; c++) begin
      req = NSRC'($urandom_range(15));
      en  = '1;
      if ($urandom_range(7) == 0) en[$urandom_range(NSRC - 1)] = 1'b0;
      applyStimulus(req, en, ($urandom_range(49) == 0), 0, $urandom_range(1));
    end

    for (int c = 0; c < 8; c++) applyStimulus(4'b0000, 4'hF, 0, 0, 1);
    applyStimulus(4'b0000, 4'hF, 0, 0, 0);
    checkOutput("drained_occ", int'(bus.occupancy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
